// File: rtl/pe_array_stream.sv
// Weight-stationary systolic matrix unit: out_data[j] = sum_i in_data[i]*W[i][j].
// Input skew and output deskew happen inside, so every column of one result
// appears on the same cycle, LATENCY cycles after the input beat.
// Weights are double-buffered: rows load into a shadow bank while the active
// bank computes, and the banks swap once the array has drained.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. The source holds its data stable while valid is high. The sink may
// raise or drop ready on any cycle. out_valid has no backpressure.
module pe_array_stream #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DATA_W   = 4,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [COLS-1:0][DATA_W-1:0]  w_row,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]  in_data,
  output logic                         out_valid,
  output logic [COLS-1:0][ACC_W-1:0]   out_data,
  output logic [COLS-1:0]              out_sat,
  output logic                         busy
);

  localparam int LATENCY = ROWS + COLS;
  localparam int PW      = 2 * DATA_W;
  localparam int SW      = PW + $clog2(ROWS);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = $clog2(LATENCY + 1);
  localparam int ACW     = (COLS > 1) ? COLS - 1 : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

  state_t                              state, state_nxt;
  logic [RW-1:0]                       wcnt;
  logic                                shadow_full;
  logic                                w_fire;
  logic                                full_evt;
  logic                                accept;
  logic [CW-1:0]                       inflight;
  logic [LATENCY-1:0]                  vsr;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_shadow;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_active;
  logic [ROWS-1:0][DATA_W-1:0]         x_g;
  logic [ROWS-1:0][DATA_W-1:0]         act_left;
  logic [ROWS-1:0][ACW-1:0][DATA_W-1:0] act_r;
  logic [ROWS-1:0][COLS-1:0][SW-1:0]   ps_r;
  logic [COLS-1:0][SW-1:0]             col_out;
  logic [COLS-1:0][ACC_W-1:0]          conv;
  logic [COLS-1:0]                     sat;

  assign w_ready   = ~shadow_full;
  assign in_ready  = (state == RUN);
  assign w_fire    = w_valid & w_ready;
  assign full_evt  = w_fire & (wcnt == RW'(ROWS - 1));
  assign accept    = in_valid & in_ready;
  assign out_valid = vsr[LATENCY-1];
  assign busy      = (inflight != '0);

  // Bank control state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: drain in-flight vectors before swapping banks
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full_evt) state_nxt = DRAIN;
      RUN:     if (full_evt) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = SWAP;
      SWAP:    state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow row loading and shadow-to-active copy
  always_ff @(posedge clk) begin
    if (rst) begin
      w_shadow    <= '0;
      w_active    <= '0;
      wcnt        <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (w_fire) begin
        w_shadow[wcnt] <= w_row;
        if (wcnt == RW'(ROWS - 1)) begin
          wcnt        <= '0;
          shadow_full <= 1'b1;
        end else begin
          wcnt <= wcnt + RW'(1);
        end
      end
      if (state == SWAP) begin
        w_active    <= w_shadow;
        shadow_full <= 1'b0;
      end
    end
  end

  // Non-accepted cycles feed zeros so the array never carries stale operands
  assign x_g = accept ? in_data : '0;

  // Input skew: row i is delayed by i cycles
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign act_left[i] = x_g[i];
    end else begin : g_dly
      logic [i-1:0][DATA_W-1:0] sk;
      // Shift register of depth i
      always_ff @(posedge clk) begin
        if (rst) begin
          sk <= '0;
        end else begin
          sk[0] <= x_g[i];
          for (int k = 1; k < i; k++) sk[k] <= sk[k-1];
        end
      end
      assign act_left[i] = sk[i-1];
    end
  end

  // Processing elements: activation passes right, partial sum passes down
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [DATA_W-1:0] a_in;
      logic signed [DATA_W-1:0] w_ij;
      logic signed [SW-1:0]     p_in;
      logic signed [PW-1:0]     prod;
      logic signed [SW-1:0]     p_q;

      if (j == 0) begin : g_al
        assign a_in = act_left[i];
      end else begin : g_ar
        assign a_in = act_r[i][j-1];
      end
      if (i == 0) begin : g_pt
        assign p_in = '0;
      end else begin : g_pa
        assign p_in = ps_r[i-1][j];
      end

      assign w_ij = w_active[i][j];
      assign prod = PW'(a_in) * PW'(w_ij);

      // Partial sum register
      always_ff @(posedge clk) begin
        if (rst) p_q <= '0;
        else     p_q <= p_in + SW'(prod);
      end
      assign ps_r[i][j] = p_q;

      // The last column has no right-hand neighbour, so no activation register
      if (j < COLS - 1) begin : g_areg
        logic [DATA_W-1:0] a_q;
        // Activation register toward the right-hand neighbour
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in;
        end
        assign act_r[i][j] = a_q;
      end
    end
  end

  // Output deskew: column j is delayed by COLS-1-j cycles
  for (genvar j = 0; j < COLS; j++) begin : g_dsk
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign col_out[j] = ps_r[ROWS-1][j];
    end else begin : g_dly
      logic [D-1:0][SW-1:0] dq;
      // Shift register of depth COLS-1-j
      always_ff @(posedge clk) begin
        if (rst) begin
          dq <= '0;
        end else begin
          dq[0] <= ps_r[ROWS-1][j];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign col_out[j] = dq[D-1];
    end
  end

  // Conversion of the exact internal sum to ACC_W (wrap or clamp)
  for (genvar j = 0; j < COLS; j++) begin : g_conv
    if (ACC_W >= SW) begin : g_ext
      assign conv[j] = ACC_W'($signed(col_out[j]));
      assign sat[j]  = 1'b0;
    end else begin : g_narrow
      logic [SW-ACC_W:0] hi;
      logic              ovf_pos;
      logic              ovf_neg;
      logic              clamp;
      // Bits above the ACC_W sign bit must all equal the sign for the value to fit
      assign hi      = col_out[j][SW-1:ACC_W-1];
      assign ovf_pos = ~col_out[j][SW-1] & (|hi);
      assign ovf_neg =  col_out[j][SW-1] & ~(&hi);
      assign clamp   = (SATURATE != 0) & (ovf_pos | ovf_neg);
      assign sat[j]  = clamp;
      assign conv[j] = !clamp  ? col_out[j][ACC_W-1:0] :
                       ovf_pos ? {1'b0, {(ACC_W-1){1'b1}}} :
                                 {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  // Beat-flag pipeline aligned with the datapath
  always_ff @(posedge clk) begin
    if (rst) vsr <= '0;
    else     vsr <= {vsr[LATENCY-2:0], accept};
  end

  // Result register: loads only for valid vectors, otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sat  <= '0;
    end else begin
      if (vsr[LATENCY-2]) out_data <= conv;
      out_sat <= vsr[LATENCY-2] ? sat : '0;
    end
  end

  // In-flight vector count, bounded by LATENCY
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, out_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
